// File: rtl/rx_protocol_pkg.sv
// Shared types and PID codes for the USB endpoint receive controller.
// Imported by the controller and its timeout counter.
package rx_protocol_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_TOKEN,
    S_WAIT_DATA,
    S_RX_DATA,
    S_WAIT_TX,
    S_WAIT_ACK,
    S_RX_ACK
  } state_e;

  typedef enum logic [2:0] {
    TX_NONE  = 3'd0,
    TX_ACK   = 3'd1,
    TX_NAK   = 3'd2,
    TX_DATA0 = 3'd3,
    TX_DATA1 = 3'd4
  } tx_pkt_e;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

endpackage

// File: rtl/rx_protocol_ctrl_timeout_counter.sv
// Idle-wait watchdog: counts enabled cycles and flags the last one
// of the allowed window.
module timeout_counter
  import rx_protocol_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 128,
  parameter int TO_W           = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  assign expired = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_protocol_ctrl.sv
// Packet-level handshake sequencer for one single-buffered USB endpoint.
// Decisions are made on end-of-packet and registered into outputs.
module rx_protocol_ctrl
  import rx_protocol_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 128,
  parameter int TO_W           = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx_transfer_active,
  input  logic       rx_error,
  input  logic [3:0] rx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic       tx_done,
  output logic [2:0] tx_packet,
  output logic       tx_start,
  output logic       clear_buffer,
  output logic       data_received,
  output logic       proto_error,
  output logic       rx_toggle,
  output logic       tx_toggle
);

  state_e  state_q, state_d;
  state_e  ret_q, ret_d;
  tx_pkt_e tx_packet_q, tx_packet_d;

  logic rx_active_q;
  logic tx_start_q, tx_start_d;
  logic clear_q, clear_d;
  logic drx_q, drx_d;
  logic perr_q, perr_d;
  logic rxt_q, rxt_d;
  logic txt_q, txt_d;
  logic occ_q, occ_d;

  logic rise;
  logic eop;
  logic occ_nz;
  logic waiting;
  logic to_clear;
  logic expired;

  assign rise     = rx_transfer_active && !rx_active_q;
  assign eop      = rx_active_q && !rx_transfer_active;
  assign occ_nz   = (buffer_occupancy != '0);
  assign waiting  = (state_q == S_WAIT_DATA) || (state_q == S_WAIT_ACK);
  assign to_clear = !waiting || rise;

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timeout (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (to_clear),
    .enable (waiting),
    .expired(expired)
  );

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    tx_packet_d = tx_packet_q;
    tx_start_d  = 1'b0;
    clear_d     = 1'b0;
    drx_d       = 1'b0;
    perr_d      = perr_q;
    rxt_d       = rxt_q;
    txt_d       = txt_q;
    occ_d       = occ_q;

    unique case (state_q)
      S_IDLE: begin
        if (rise) state_d = S_RX_TOKEN;
      end

      S_RX_TOKEN: begin
        if (eop) begin
          if (rx_error) begin
            perr_d  = 1'b1;
            state_d = S_IDLE;
          end else if (rx_packet == PID_OUT) begin
            perr_d  = 1'b0;
            occ_d   = occ_nz;
            state_d = S_WAIT_DATA;
          end else if (rx_packet == PID_IN) begin
            perr_d     = 1'b0;
            tx_start_d = 1'b1;
            state_d    = S_WAIT_TX;
            if (occ_nz) begin
              tx_packet_d = txt_q ? TX_DATA1 : TX_DATA0;
              ret_d       = S_WAIT_ACK;
            end else begin
              tx_packet_d = TX_NAK;
              ret_d       = S_IDLE;
            end
          end else begin
            perr_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_WAIT_DATA: begin
        if (rise) begin
          state_d = S_RX_DATA;
        end else if (expired) begin
          perr_d  = 1'b1;
          clear_d = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_RX_DATA: begin
        if (eop) begin
          if (rx_error || !is_data_pid(rx_packet)) begin
            clear_d = 1'b1;
            perr_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            tx_start_d = 1'b1;
            ret_d      = S_IDLE;
            state_d    = S_WAIT_TX;
            // New bytes sit behind unsent old ones; refuse and let host retry.
            if (occ_q) begin
              tx_packet_d = TX_NAK;
            end else if (rx_packet[3] == rxt_q) begin
              tx_packet_d = TX_ACK;
              rxt_d       = !rxt_q;
              drx_d       = 1'b1;
            end else begin
              tx_packet_d = TX_ACK;
              clear_d     = 1'b1;
            end
          end
        end
      end

      S_WAIT_TX: begin
        if (tx_done) begin
          tx_packet_d = TX_NONE;
          state_d     = ret_q;
        end
      end

      S_WAIT_ACK: begin
        if (rise) begin
          state_d = S_RX_ACK;
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end

      S_RX_ACK: begin
        if (eop) begin
          if (!rx_error && (rx_packet == PID_ACK)) begin
            txt_d   = !txt_q;
            clear_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      tx_packet_q <= TX_NONE;
      rx_active_q <= 1'b0;
      tx_start_q  <= 1'b0;
      clear_q     <= 1'b0;
      drx_q       <= 1'b0;
      perr_q      <= 1'b0;
      rxt_q       <= 1'b0;
      txt_q       <= 1'b0;
      occ_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      tx_packet_q <= tx_packet_d;
      rx_active_q <= rx_transfer_active;
      tx_start_q  <= tx_start_d;
      clear_q     <= clear_d;
      drx_q       <= drx_d;
      perr_q      <= perr_d;
      rxt_q       <= rxt_d;
      txt_q       <= txt_d;
      occ_q       <= occ_d;
    end
  end

  assign tx_packet     = tx_packet_q;
  assign tx_start      = tx_start_q;
  assign clear_buffer  = clear_q;
  assign data_received = drx_q;
  assign proto_error   = perr_q;
  assign rx_toggle     = rxt_q;
  assign tx_toggle     = txt_q;

endmodule

// File: doc/rx_protocol_ctrl.md
Name: rx_protocol_ctrl

Overview:
Packet-level protocol controller that sequences the USB receive block for one single-buffered endpoint. It watches receive status (transfer active, error, PID, FIFO occupancy) and decides the handshake the device returns (ACK/NAK/DATAx). It tracks the RX and TX data toggles, flushes rejected or duplicate data, and times out stalled transactions. It sits between the receiver/FIFO and the transmitter.

Parameters:
TIMEOUT_CYCLES, 128, cycles allowed in WAIT_DATA/WAIT_ACK with no new packet start before abandoning the transaction.
TO_W, 8, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock
n_rst  in  1  reset, asynchronous, active-low
rx_transfer_active  in  1  high while the receiver is inside a packet
rx_error  in  1  receiver error flag, valid when rx_transfer_active falls
rx_packet  in  4  received PID nibble, valid when rx_transfer_active falls
buffer_occupancy  in  7  shared endpoint FIFO byte count (0..64)
tx_done  in  1  1-cycle pulse: transmitter finished the requested packet
tx_packet  out  3  requested TX packet: 0 NONE, 1 ACK, 2 NAK, 3 DATA0, 4 DATA1
tx_start  out  1  1-cycle pulse launching tx_packet
clear_buffer  out  1  1-cycle pulse flushing the endpoint FIFO
data_received  out  1  1-cycle pulse: good OUT data committed in FIFO
proto_error  out  1  sticky; cleared on the next accepted token
rx_toggle  out  1  expected DATA PID for next OUT (0 = DATA0)
tx_toggle  out  1  DATA PID for next IN

Behaviour:
- Reset: state IDLE; all outputs 0 (tx_packet = NONE); toggles 0; timeout counter 0.
- PID codes: OUT 4'b0001, IN 4'b1001, DATA0 4'b0011, DATA1 4'b1011, ACK 4'b0010, NAK 4'b1010. Any other code is invalid.
- The block registers rx_transfer_active. End-of-packet (EOP) = prev 1 and current 0. All decisions are taken in the EOP cycle N and take effect at N+1: tx_start, clear_buffer and data_received pulse for exactly 1 cycle; tx_packet holds its value until tx_done.
- States: IDLE, RX_TOKEN, WAIT_DATA, RX_DATA, WAIT_TX, WAIT_ACK, RX_ACK.
- IDLE: rise of rx_transfer_active -> RX_TOKEN.
- RX_TOKEN at EOP:
  - rx_error or invalid PID -> IDLE, proto_error=1, no TX.
  - OUT -> clear proto_error -> WAIT_DATA.
  - IN, occupancy 0 -> tx NAK -> WAIT_TX, then IDLE.
  - IN, occupancy >0 -> tx DATA(tx_toggle) -> WAIT_TX, then WAIT_ACK.
  - DATAx/ACK/NAK here -> proto_error=1 -> IDLE.
- WAIT_DATA: counter increments each cycle; rise of rx_transfer_active -> RX_DATA, counter cleared. Count reaching TIMEOUT_CYCLES -> IDLE, proto_error=1, clear_buffer.
- RX_DATA at EOP:
  - rx_error or non-DATA PID -> clear_buffer, proto_error=1, no handshake -> IDLE.
  - FIFO held data before this packet (occupancy flag latched at token time was nonzero) -> clear_buffer to remove this packet only if flag-0; otherwise NAK with no flush of old data. Implementation: new data was written behind old, so NAK and leave FIFO untouched (host retries).
  - PID toggle == rx_toggle -> ACK, rx_toggle flips, data_received.
  - PID toggle != rx_toggle (duplicate) -> ACK, clear_buffer, rx_toggle unchanged.
  - All handshake branches -> WAIT_TX.
- WAIT_TX: hold tx_packet until tx_done, then set tx_packet=NONE and go to the stored next state.
- WAIT_ACK: same timeout as WAIT_DATA. Timeout -> IDLE with tx_toggle unchanged (retry), no error. Rise -> RX_ACK.
- RX_ACK at EOP: valid ACK with no error -> tx_toggle flips and clear_buffer (data delivered). Anything else -> tx_toggle unchanged, proto_error=1. Both -> IDLE.
- A rise of rx_transfer_active in WAIT_TX is ignored. tx_done outside WAIT_TX is ignored.
- If EOP and tx_done coincide, only the event valid for the current state is acted on.
- Asynchronous reset mid-transaction returns to the reset values immediately; no pulses are emitted.

Decomposition:
- Package rx_protocol_pkg: state enum; PID localparams; tx_packet code enum (NONE/ACK/NAK/DATA0/DATA1).
- Sub-module timeout_counter: clear/enable inputs, terminal-count output, parameterised by TIMEOUT_CYCLES.
- EOP detection and the FSM stay in the top module.

Test Plan:
- OUT, then DATA0 with occupancy 0 -> tx_packet=1 (ACK) and tx_start one cycle after EOP, data_received=1, rx_toggle 0->1.
- Repeat DATA0 after that (duplicate) -> ACK, clear_buffer pulse, rx_toggle stays 1, no data_received.
- IN with occupancy 0 -> NAK. IN with occupancy 8 -> DATA0; host ACK -> tx_toggle=1 and clear_buffer. Next IN -> DATA1.
- OUT, then no packet for 128 cycles -> IDLE, proto_error=1, clear_buffer pulse. Next OUT clears proto_error.
- DATA1 received with rx_error=1 at EOP -> clear_buffer, no tx_start, proto_error=1.
- Assert n_rst low while in WAIT_TX -> all outputs 0 and toggles 0 immediately. Later tx_done is ignored.
